// File: rtl/fb_scanout.sv
// fb_scanout: raster-order framebuffer reader and 640x480@60 video timing generator.
//
// Reads a 256x256 8-bit framebuffer (address {x, y}) through an independent BRAM port,
// centres the image inside the active area and emits a pixel stream for the encoder.
//
// Ports:
//   clk, rst_n          pixel clock, asynchronous active-low reset
//   enable_i            scanout run request, sampled at the last pixel of each frame
//   fb_rd_addr_o/en_o   framebuffer read request ({x, y})
//   fb_rd_data_i        read data, valid RD_LATENCY cycles after fb_rd_en_o
//   pix_data_o/de_o     RGB332 pixel and data enable
//   hsync_o, vsync_o    active-low syncs, aligned with pix_*
//   vblank_o            high while v_cnt >= V_ACTIVE (undelayed)
//   frame_start_o       one-cycle pulse at counter (0,0) while running (undelayed)
//   debug_info_o        {state[1:0], v_cnt, h_cnt, 10'b0}
//
// Build option: define SCANOUT_BORDER_EN to draw an 8'hFF ring one pixel outside the window.
module fb_scanout #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned X_OFS      = 192,
    parameter int unsigned Y_OFS      = 112,
    parameter int unsigned RD_LATENCY = 2,
    parameter logic [7:0]  BG_COLOR   = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable_i,
    output logic [15:0] fb_rd_addr_o,
    output logic        fb_rd_en_o,
    input  logic [7:0]  fb_rd_data_i,
    output logic [7:0]  pix_data_o,
    output logic        pix_de_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        vblank_o,
    output logic        frame_start_o,
    output logic [31:0] debug_info_o
);
    localparam int unsigned HTotal = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned VTotal = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  HLast     = 10'(HTotal - 1);
    localparam logic [9:0]  VLast     = 10'(VTotal - 1);
    localparam logic [10:0] HAct      = 11'(H_ACTIVE);
    localparam logic [10:0] VAct      = 11'(V_ACTIVE);
    localparam logic [10:0] HSyncBeg  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HSyncEnd  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VSyncBeg  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VSyncEnd  = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] XBeg      = 11'(X_OFS);
    localparam logic [10:0] XEnd      = 11'(X_OFS + 256);
    localparam logic [10:0] YBeg      = 11'(Y_OFS);
    localparam logic [10:0] YEnd      = 11'(Y_OFS + 256);
    localparam logic [2:0]  DrainLast = 3'(RD_LATENCY);

    typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StDrain = 2'd2} state_e;

    // Control bits that travel alongside the framebuffer read.
    typedef struct packed {
        logic active;
        logic in_win;
        logic border;
        logic hs;
        logic vs;
    } ctl_t;

    // Syncs reset deasserted so a flushing pipeline never produces a spurious sync pulse.
    localparam ctl_t CtlIdle = '{active: 1'b0, in_win: 1'b0, border: 1'b0, hs: 1'b1, vs: 1'b1};

    state_e     state_q, state_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic [2:0] drain_q, drain_d;

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                drain_d = '0;
                if (enable_i) state_d = StRun;
            end
            StRun: begin
                drain_d = '0;
                if (h_cnt_q == HLast) begin
                    h_cnt_d = '0;
                    if (v_cnt_q == VLast) begin
                        v_cnt_d = '0;
                        // Only place enable is looked at: frames are never cut short.
                        if (!enable_i) state_d = StDrain;
                    end else begin
                        v_cnt_d = v_cnt_q + 10'd1;
                    end
                end else begin
                    h_cnt_d = h_cnt_q + 10'd1;
                end
            end
            StDrain: begin
                h_cnt_d = '0;
                v_cnt_d = '0;
                drain_d = drain_q + 3'd1;
                // RD_LATENCY+1 cycles lets the last read and its control bits reach the outputs.
                if (drain_q == DrainLast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Stage 0: decode the counter position.
    logic        run;
    logic [10:0] h_ext, v_ext;
    logic        active_s0, in_win_s0, hs_s0, vs_s0, border_s0;
    ctl_t        ctl_s0, ctl_out;

    assign run       = (state_q == StRun);
    assign h_ext     = {1'b0, h_cnt_q};
    assign v_ext     = {1'b0, v_cnt_q};
    assign active_s0 = run && (h_ext < HAct) && (v_ext < VAct);
    assign in_win_s0 = run && (h_ext >= XBeg) && (h_ext < XEnd) && (v_ext >= YBeg) && (v_ext < YEnd);
    assign hs_s0     = !(run && (h_ext >= HSyncBeg) && (h_ext < HSyncEnd));
    assign vs_s0     = !(run && (v_ext >= VSyncBeg) && (v_ext < VSyncEnd));

`ifdef SCANOUT_BORDER_EN
    localparam logic [10:0] XRing = XBeg - 11'd1;
    localparam logic [10:0] YRing = YBeg - 11'd1;

    // Ring columns XRing/XEnd and ring lines YRing/YEnd; in_win has priority downstream.
    assign border_s0 = run &&
        ((((h_ext == XRing) || (h_ext == XEnd)) && (v_ext >= YRing) && (v_ext <= YEnd)) ||
         (((v_ext == YRing) || (v_ext == YEnd)) && (h_ext >= XRing) && (h_ext <= XEnd)));
`else
    assign border_s0 = 1'b0;
`endif

    assign ctl_s0 = '{active: active_s0, in_win: in_win_s0, border: border_s0,
                      hs: hs_s0, vs: vs_s0};

    // ctl_q[0] is stage 1; ctl_q[RD_LATENCY] lines up with fb_rd_data_i.
    ctl_t [RD_LATENCY:0] ctl_q;
    logic [7:0]          pix_d;

    assign ctl_out = ctl_q[RD_LATENCY];

    // Blanking forces 0 even where the window extends past the active area.
    always_comb begin
        pix_d = 8'h00;
        if (ctl_out.active) begin
            if (ctl_out.in_win)      pix_d = fb_rd_data_i;
            else if (ctl_out.border) pix_d = 8'hFF;
            else                     pix_d = BG_COLOR;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            drain_q      <= '0;
            fb_rd_en_o   <= 1'b0;
            fb_rd_addr_o <= '0;
            ctl_q        <= {(RD_LATENCY + 1){CtlIdle}};
            pix_data_o   <= 8'h00;
            pix_de_o     <= 1'b0;
            hsync_o      <= 1'b1;
            vsync_o      <= 1'b1;
        end else begin
            state_q    <= state_d;
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            drain_q    <= drain_d;
            fb_rd_en_o <= in_win_s0;
            if (in_win_s0) begin
                fb_rd_addr_o <= {8'(h_cnt_q - 10'(X_OFS)), 8'(v_cnt_q - 10'(Y_OFS))};
            end
            ctl_q      <= {ctl_q[RD_LATENCY-1:0], ctl_s0};
            pix_data_o <= pix_d;
            pix_de_o   <= ctl_out.active;
            hsync_o    <= ctl_out.hs;
            vsync_o    <= ctl_out.vs;
        end
    end

    assign vblank_o      = (v_cnt_q >= 10'(V_ACTIVE));
    assign frame_start_o = run && (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    assign debug_info_o  = {state_q, v_cnt_q, h_cnt_q, 10'b0};

endmodule

// File: tb/tb_fb_scanout.sv
// Testbench for fb_scanout: three instances (RD_LATENCY 1, 2, 4) on a reduced raster so whole
// frames stay short, each fed by a framebuffer model holding x^y.
module tb_fb_scanout;
    localparam int HA = 280, HFP = 4, HSW = 8, HBP = 8, HT = HA + HFP + HSW + HBP;
    localparam int VA = 12, VFP = 2, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
    localparam int XO = 10, YO = 3, FRAME = HT * VT;
    localparam logic [7:0] BG = 8'h3C;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic enable = 1'b0;
    always #5 clk = ~clk;

    logic [15:0] addr1, addr2, addr4;
    logic        en1, en2, en4;
    logic [7:0]  rd1, rd2, rd4, pix1, pix2, pix4;
    logic        de1, de2, de4, hs1, hs2, hs4, vs1, vs2, vs4;
    logic        vb1, vb2, vb4, fs1, fs2, fs4;
    logic [31:0] dbg1, dbg2, dbg4;
    logic [10:0] o1, o2, o4;

    assign o1 = {de1, hs1, vs1, pix1};
    assign o2 = {de2, hs2, vs2, pix2};
    assign o4 = {de4, hs4, vs4, pix4};

    fb_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
                 .V_SYNC(VSW), .V_BP(VBP), .X_OFS(XO), .Y_OFS(YO), .RD_LATENCY(1), .BG_COLOR(BG))
    u_dut1 (.clk(clk), .rst_n(rst_n), .enable_i(enable), .fb_rd_addr_o(addr1), .fb_rd_en_o(en1),
            .fb_rd_data_i(rd1), .pix_data_o(pix1), .pix_de_o(de1), .hsync_o(hs1), .vsync_o(vs1),
            .vblank_o(vb1), .frame_start_o(fs1), .debug_info_o(dbg1));

    fb_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
                 .V_SYNC(VSW), .V_BP(VBP), .X_OFS(XO), .Y_OFS(YO), .RD_LATENCY(2), .BG_COLOR(BG))
    u_dut2 (.clk(clk), .rst_n(rst_n), .enable_i(enable), .fb_rd_addr_o(addr2), .fb_rd_en_o(en2),
            .fb_rd_data_i(rd2), .pix_data_o(pix2), .pix_de_o(de2), .hsync_o(hs2), .vsync_o(vs2),
            .vblank_o(vb2), .frame_start_o(fs2), .debug_info_o(dbg2));

    fb_scanout #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP), .V_ACTIVE(VA), .V_FP(VFP),
                 .V_SYNC(VSW), .V_BP(VBP), .X_OFS(XO), .Y_OFS(YO), .RD_LATENCY(4), .BG_COLOR(BG))
    u_dut4 (.clk(clk), .rst_n(rst_n), .enable_i(enable), .fb_rd_addr_o(addr4), .fb_rd_en_o(en4),
            .fb_rd_data_i(rd4), .pix_data_o(pix4), .pix_de_o(de4), .hsync_o(hs4), .vsync_o(vs4),
            .vblank_o(vb4), .frame_start_o(fs4), .debug_info_o(dbg4));

    // Framebuffer models: mem[{x,y}] = x^y; 8'hA5 marks data from a cycle without a read.
    logic [7:0] m1_q;
    logic [7:0] m2_q [2];
    logic [7:0] m4_q [4];
    always_ff @(posedge clk) begin
        m1_q    <= en1 ? (addr1[15:8] ^ addr1[7:0]) : 8'hA5;
        m2_q[0] <= en2 ? (addr2[15:8] ^ addr2[7:0]) : 8'hA5;
        m2_q[1] <= m2_q[0];
        m4_q[0] <= en4 ? (addr4[15:8] ^ addr4[7:0]) : 8'hA5;
        for (int i = 1; i < 4; i++) m4_q[i] <= m4_q[i-1];
    end
    assign rd1 = m1_q;
    assign rd2 = m2_q[1];
    assign rd4 = m4_q[3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int run_start = 0;

    typedef struct {
        int          due;
        int          h;
        int          v;
        logic [10:0] exp;
    } sb_t;
    sb_t q1[$], q2[$], q4[$];

    // Expected {de, hsync, vsync, pix} for a counter position.
    function automatic logic [10:0] exp_out(int h, int v);
        logic       act, win, hs, vs, brd;
        logic [7:0] xa, ya, pix;
        act = (h < HA) && (v < VA);
        win = (h >= XO) && (h < XO + 256) && (v >= YO) && (v < YO + 256);
        hs  = !((h >= HA + HFP) && (h < HA + HFP + HSW));
        vs  = !((v >= VA + VFP) && (v < VA + VFP + VSW));
        brd = 1'b0;
`ifdef SCANOUT_BORDER_EN
        brd = (((h == XO - 1) || (h == XO + 256)) && (v >= YO - 1) && (v <= YO + 256)) ||
              (((v == YO - 1) || (v == YO + 256)) && (h >= XO - 1) && (h <= XO + 256));
`endif
        xa = 8'(h - XO);
        ya = 8'(v - YO);
        if (!act)     pix = 8'h00;
        else if (win) pix = xa ^ ya;
        else if (brd) pix = 8'hFF;
        else          pix = BG;
        return {act, hs, vs, pix};
    endfunction

    function automatic int pos_now();
        return (cyc - run_start) % FRAME;
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        enable = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) step();
        checks++;
        if ({en1, addr1, pix1, de1, hs1, vs1, vb1, fs1} !== {1'b0, 16'h0, 8'h0, 5'b01100})
            begin errors++; $display("FAIL reset_dut1 got %h", {en1, addr1, pix1, de1, hs1, vs1, vb1, fs1}); end
        checks++;
        if ({en2, addr2, pix2, de2, hs2, vs2, vb2, fs2} !== {1'b0, 16'h0, 8'h0, 5'b01100})
            begin errors++; $display("FAIL reset_dut2 got %h", {en2, addr2, pix2, de2, hs2, vs2, vb2, fs2}); end
        checks++;
        if ({en4, addr4, pix4, de4, hs4, vs4, vb4, fs4} !== {1'b0, 16'h0, 8'h0, 5'b01100})
            begin errors++; $display("FAIL reset_dut4 got %h", {en4, addr4, pix4, de4, hs4, vs4, vb4, fs4}); end
        rst_n = 1'b1;
        repeat (5) step();
        checks++;
        if ({en2, de2, hs2, vs2, fs2, dbg2[29:0]} !== {5'b00110, 30'h0})
            begin errors++; $display("FAIL idle_hold got %h want %h", {en2, de2, hs2, vs2, fs2, dbg2[29:0]}, {5'b00110, 30'h0}); end
    endtask

    // One full frame plus a few cycles, all three latencies checked through scoreboards.
    task automatic test_stream();
        int   h, v, hp, vp;
        logic exp_en;
        sb_t  e;
        enable = 1'b1;
        step();
        run_start = cyc;
        for (int n = 0; n < FRAME + 10; n++) begin
            h = n % HT;
            v = (n / HT) % VT;
            checks++;
            if ({fs2, vb2} !== {(h == 0 && v == 0), (v >= VA)})
                begin errors++; $display("FAIL stage0_fs_vblank at (%0d,%0d) got %b want %b", h, v, {fs2, vb2}, {(h == 0 && v == 0), (v >= VA)}); end
            if (n > 0) begin
                hp = (n - 1) % HT;
                vp = ((n - 1) / HT) % VT;
                exp_en = (hp >= XO) && (hp < XO + 256) && (vp >= YO) && (vp < YO + 256);
                checks++;
                if (en2 !== exp_en || (exp_en && addr2 !== {8'(hp - XO), 8'(vp - YO)}))
                    begin errors++; $display("FAIL rd_req at (%0d,%0d) got en=%b addr=%h want en=%b addr=%h", hp, vp, en2, addr2, exp_en, {8'(hp - XO), 8'(vp - YO)}); end
            end
            e.h = h; e.v = v; e.exp = exp_out(h, v);
            e.due = n + 3; q1.push_back(e);
            e.due = n + 4; q2.push_back(e);
            e.due = n + 6; q4.push_back(e);
            if (q1.size() > 0 && q1[0].due == n) begin
                e = q1.pop_front(); checks++;
                if (o1 !== e.exp) begin errors++; $display("FAIL out_lat1 at (%0d,%0d) got %h want %h", e.h, e.v, o1, e.exp); end
            end
            if (q2.size() > 0 && q2[0].due == n) begin
                e = q2.pop_front(); checks++;
                if (o2 !== e.exp) begin errors++; $display("FAIL out_lat2 at (%0d,%0d) got %h want %h", e.h, e.v, o2, e.exp); end
            end
            if (q4.size() > 0 && q4[0].due == n) begin
                e = q4.pop_front(); checks++;
                if (o4 !== e.exp) begin errors++; $display("FAIL out_lat4 at (%0d,%0d) got %h want %h", e.h, e.v, o4, e.exp); end
            end
            step();
        end
        q1.delete(); q2.delete(); q4.delete();
    endtask

    // Enable dropped mid-frame: frame finishes, then drain and idle with no new frame_start.
    task automatic test_drain();
        logic any_fs;
        while (pos_now() != 5 * HT + 20) step();
        enable = 1'b0;
        while (pos_now() != FRAME - 1) step();
        checks++;
        if (dbg2[29:0] !== {10'(VT - 1), 10'(HT - 1), 10'b0})
            begin errors++; $display("FAIL frame_completes got %h want %h", dbg2[29:0], {10'(VT - 1), 10'(HT - 1), 10'b0}); end
        step();
        checks++;
        if ({dbg2[29:0], fs2, en2} !== 32'h0)
            begin errors++; $display("FAIL drain_counters got %h want 0", {dbg2[29:0], fs2, en2}); end
        any_fs = 1'b0;
        for (int k = 0; k < 30; k++) begin
            step();
            any_fs = any_fs | fs1 | fs2 | fs4;
        end
        checks++;
        if (any_fs !== 1'b0) begin errors++; $display("FAIL no_frame_start_idle got %b want 0", any_fs); end
        checks++;
        if ({de1, hs1, vs1, en1, de2, hs2, vs2, en2, de4, hs4, vs4, en4} !== 12'b011001100110)
            begin errors++; $display("FAIL idle_outputs got %b want 011001100110", {de1, hs1, vs1, en1, de2, hs2, vs2, en2, de4, hs4, vs4, en4}); end
    endtask

    // Drain length: enable re-raised during DRAIN is ignored until IDLE.
    task automatic test_drain_len();
        int at1, at2, at4, set_cyc;
        enable = 1'b1;
        step();
        run_start = cyc;
        checks++;
        if ({fs1, fs2, fs4} !== 3'b111) begin errors++; $display("FAIL restart_from_idle got %b want 111", {fs1, fs2, fs4}); end
        enable = 1'b0;
        while (pos_now() != FRAME - 1) step();
        step();
        enable = 1'b1;
        set_cyc = cyc;
        at1 = -1; at2 = -1; at4 = -1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (fs1 && at1 < 0) at1 = k;
            if (fs2 && at2 < 0) at2 = k;
            if (fs4 && at4 < 0) at4 = k;
        end
        checks++;
        if (at1 !== 3) begin errors++; $display("FAIL drain_len_lat1 got %0d want 3", at1); end
        checks++;
        if (at2 !== 4) begin errors++; $display("FAIL drain_len_lat2 got %0d want 4", at2); end
        checks++;
        if (at4 !== 6) begin errors++; $display("FAIL drain_len_lat4 got %0d want 6", at4); end
        run_start = set_cyc + 4;
    endtask

    task automatic test_async_reset();
        int found;
        while (pos_now() != 8 * HT + 150) step();
        checks++;
        if (o2 !== exp_out(146, 8)) begin errors++; $display("FAIL pre_reset_pixel got %h want %h", o2, exp_out(146, 8)); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({en1, addr1, pix1, de1, hs1, vs1, fs1, dbg1[29:0]} !== {1'b0, 16'h0, 8'h0, 4'b0110, 30'h0})
            begin errors++; $display("FAIL async_reset_dut1 got %h", {en1, addr1, pix1, de1, hs1, vs1, fs1, dbg1[29:0]}); end
        checks++;
        if ({en2, addr2, pix2, de2, hs2, vs2, fs2, dbg2[29:0]} !== {1'b0, 16'h0, 8'h0, 4'b0110, 30'h0})
            begin errors++; $display("FAIL async_reset_dut2 got %h", {en2, addr2, pix2, de2, hs2, vs2, fs2, dbg2[29:0]}); end
        checks++;
        if ({en4, addr4, pix4, de4, hs4, vs4, fs4, dbg4[29:0]} !== {1'b0, 16'h0, 8'h0, 4'b0110, 30'h0})
            begin errors++; $display("FAIL async_reset_dut4 got %h", {en4, addr4, pix4, de4, hs4, vs4, fs4, dbg4[29:0]}); end
        step();
        enable = 1'b1;
        rst_n = 1'b1;
        found = 0;
        for (int k = 1; k <= 2; k++) begin
            step();
            if (fs2 && found == 0) begin
                found = k;
                checks++;
                if (dbg2[29:0] !== 30'h0) begin errors++; $display("FAIL restart_origin got %h want 0", dbg2[29:0]); end
            end
        end
        checks++;
        if (found == 0) begin errors++; $display("FAIL restart_after_reset got no frame_start want pulse within 2 cycles"); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_drain();
        test_drain_len();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
